calc_param: RTL
===============

// Module: calc_param
// PURPOSE
// Parametrised successor of the 8-digit calculator. Accepts keypad commands with a
// valid/ready handshake; supports add, subtract and multiply on decimal operands of
// up to DIGITS digits, with overflow detection, a sign flag and a clear command.
// Sits between the keypad decoder and the multiplexed 7-segment display driver.
// PARAMETERS
// DIGITS  8   decimal display digits; max operand/result MAXVAL = 10^DIGITS-1
// WIDTH   27  binary value width; must satisfy 2^WIDTH > MAXVAL
// POS_W   4   width of pos; must satisfy 2^POS_W >= DIGITS
// PORTS
// clock      in   1      system clock, rising edge
// reset      in   1      asynchronous, active-low reset
// cmd        in   4      0-9 digit, A add, B sub, C mul, D clear, E equals, F backspace
// cmd_valid  in   1      cmd qualifier; consumed only when status==10
// status     out  2      00 error, 01 busy, 10 ready
// data       out  4      BCD digit for display position pos
// pos        out  POS_W  display index, 0 = least significant digit
// disp_we    out  1      data/pos valid this cycle; display latches them
// neg        out  1      displayed value is negative
// state      out  3      FSM state, debug
// BEHAVIOUR
// - Reset (reset=0): value=0, regA=0, op=none, neg=0, data=0, pos=0, disp_we=0,
//   status=01, state=REFRESH; on release a zero refresh runs, then ENT_A, status=10.
// - Accept: cmd_valid=1 and status==10 at a rising edge; status=01 on the next cycle.
//   cmd_valid while status!=10 is ignored (except clear in ERR).
// - States: ENT_A 000, OP_WAIT 010, ENT_B 001, MUL 011, ERR 100, REFRESH 101.
// - Digit d (ENT_A/ENT_B): value=value*10+d; ignored (no busy, status stays 10) if
//   result>MAXVAL. First digit after a completed '=' starts a fresh value, clears neg.
// - Backspace: value=value/10 (truncating); neg unchanged; refresh.
// - Clear (D): any state incl. ERR -> value=0, regA=0, op=none, neg=0, refresh, ENT_A.
// - Operator in ENT_A: regA=value, op=cmd, value=0 -> OP_WAIT. neg=1 -> ERR.
// - Operator in OP_WAIT: replaces op, no refresh, stays OP_WAIT, status stays 10.
// - Digit in OP_WAIT -> starts B, goes ENT_B. Operator in ENT_B -> ERR.
// - '=' in ENT_A or OP_WAIT ignored (status stays 10). '=' in ENT_B:
//   add: regA+value; >MAXVAL -> ERR.  sub: |regA-value|, neg=(regA<value).
//   mul: MUL state, shift-add, exactly WIDTH cycles, 2*WIDTH-bit product;
//   product>MAXVAL -> ERR. Result loaded into value, refresh, then ENT_A.
// - REFRESH: WIDTH cycles iterative binary-to-BCD (double dabble), then DIGITS
//   cycles with disp_we=1, pos=0..DIGITS-1 ascending, data=BCD digit (leading
//   zeros shown as 0); then disp_we=0, pos=0, status=10.
// - Latency accept->ready: WIDTH+DIGITS+1 cycles; multiply adds WIDTH cycles.
//   DIGITS=8,WIDTH=27: 36 cycles, multiply 63 cycles.
// - ERR: status=00 immediately, display not refreshed, only clear or reset exits.
// - Reset mid-MUL or mid-REFRESH: all state discarded immediately, reset values.
// - state output combinational from FSM register; all other outputs registered.
// TESTING
// 1: reset, wait 36 cycles -> 8 writes pos0..7 data=0; status=10, neg=0.
// 2: 1,2,A,3,4,E -> final refresh pos0=6,pos1=4,pos2..7=0; neg=0.
// 3: 5,B,9,E -> pos0=4, others 0, neg=1; then A -> status=00, state=100.
// 4: 1,2,3,4,C,5,6,7,E -> 699678 (pos0=8..pos5=6); ready exactly 63 cycles after '='.
// 5: 9 x8 then A,1,E -> status=00; D -> zero refresh, status=10, state=000.
//    Also 9th digit after 8 nines -> ignored, no disp_we.
// 6: 1,2,3,F -> refresh shows 12; assert reset mid-multiply -> outputs at reset values.

Source files
------------

// File: rtl/calc_param.sv
// Keypad calculator core: decimal entry, add/subtract/shift-add multiply, and an
// iterative binary-to-BCD refresh that streams digits to the 7-segment driver.
module calc_param #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned POS_W  = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [3:0]       i_cmd,
    input  logic             i_cmd_valid,
    output logic [1:0]       o_status,
    output logic [3:0]       o_data,
    output logic [POS_W-1:0] o_pos,
    output logic             o_disp_we,
    output logic             o_neg,
    output logic [2:0]       o_state
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH + DIGITS + 1);

    localparam logic [PROD_W-1:0] MAXVAL       = PROD_W'(pow10(DIGITS) - 64'd1);
    localparam logic [CNT_W-1:0]  CNT_CONV_END = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_DISP_END = CNT_W'(WIDTH + DIGITS);
    localparam logic [CNT_W-1:0]  CNT_MUL_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'hA;
    localparam logic [3:0] CMD_SUB = 4'hB;
    localparam logic [3:0] CMD_MUL = 4'hC;
    localparam logic [3:0] CMD_CLR = 4'hD;
    localparam logic [3:0] CMD_EQ  = 4'hE;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    typedef enum logic [2:0] {
        S_ENT_A   = 3'b000,
        S_ENT_B   = 3'b001,
        S_OP_WAIT = 3'b010,
        S_MUL     = 3'b011,
        S_ERR     = 3'b100,
        S_REFRESH = 3'b101
    } state_t;

    state_t             r_state, w_state_nxt;
    state_t             r_ret, w_ret_nxt;
    logic [WIDTH-1:0]   r_value, w_value_nxt;
    logic [WIDTH-1:0]   r_rega, w_rega_nxt;
    logic [1:0]         r_op, w_op_nxt;
    logic               r_neg, w_neg_nxt;
    logic               r_done, w_done_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_bin, w_bin_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
    logic [PROD_W-1:0]  r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [PROD_W-1:0]  r_prod, w_prod_nxt;
    logic [1:0]         r_status, w_status_nxt;
    logic [3:0]         r_data, w_data_nxt;
    logic [POS_W-1:0]   r_pos, w_pos_nxt;
    logic               r_disp_we, w_disp_we_nxt;

    logic               w_accept, w_is_digit, w_is_op, w_fresh;
    logic               w_go_refresh, w_go_err, w_clear;
    logic [WIDTH-1:0]   w_base;
    logic [PROD_W-1:0]  w_append, w_sum, w_prod_step;
    logic [1:0]         w_op_sel;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   w_digit_idx;
    logic [3:0]         w_digit;

    assign w_accept    = i_cmd_valid && (r_status == ST_READY);
    assign w_is_digit  = (i_cmd <= 4'd9);
    assign w_is_op     = (i_cmd >= CMD_ADD) && (i_cmd <= CMD_MUL);
    // A digit after OP_WAIT or after a completed '=' starts a new number
    assign w_fresh     = (r_state == S_OP_WAIT) || ((r_state == S_ENT_A) && r_done);
    assign w_base      = w_fresh ? '0 : r_value;
    assign w_append    = PROD_W'(w_base) * PROD_W'(10) + PROD_W'(i_cmd);
    assign w_sum       = PROD_W'(r_rega) + PROD_W'(r_value);
    assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_digit_idx = r_cnt - CNT_CONV_END;

    always_comb begin
        case (i_cmd)
            CMD_ADD: w_op_sel = OP_ADD;
            CMD_SUB: w_op_sel = OP_SUB;
            CMD_MUL: w_op_sel = OP_MUL;
            default: w_op_sel = OP_NONE;
        endcase
    end

    // Double-dabble add-3 correction applied before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (w_digit_idx == CNT_W'(k)) w_digit = r_bcd[4*k +: 4];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret;
        w_value_nxt   = r_value;
        w_rega_nxt    = r_rega;
        w_op_nxt      = r_op;
        w_neg_nxt     = r_neg;
        w_done_nxt    = r_done;
        w_cnt_nxt     = r_cnt;
        w_bin_nxt     = r_bin;
        w_bcd_nxt     = r_bcd;
        w_mcand_nxt   = r_mcand;
        w_mplier_nxt  = r_mplier;
        w_prod_nxt    = r_prod;
        w_status_nxt  = r_status;
        w_data_nxt    = r_data;
        w_pos_nxt     = r_pos;
        w_disp_we_nxt = 1'b0;
        w_go_refresh  = 1'b0;
        w_go_err      = 1'b0;
        w_clear       = 1'b0;

        case (r_state)
            S_ENT_A, S_ENT_B, S_OP_WAIT: begin
                if (w_accept) begin
                    if (i_cmd == CMD_CLR) begin
                        w_clear = 1'b1;
                    end else if (w_is_digit) begin
                        if (w_append <= MAXVAL) begin
                            w_value_nxt  = WIDTH'(w_append);
                            w_done_nxt   = 1'b0;
                            if ((r_state == S_ENT_A) && r_done) w_neg_nxt = 1'b0;
                            w_ret_nxt    = (r_state == S_ENT_A) ? S_ENT_A : S_ENT_B;
                            w_go_refresh = 1'b1;
                        end
                    end else if (w_is_op) begin
                        if (r_state == S_ENT_A) begin
                            if (r_neg) begin
                                w_go_err = 1'b1;
                            end else begin
                                w_rega_nxt   = r_value;
                                w_op_nxt     = w_op_sel;
                                w_value_nxt  = '0;
                                w_done_nxt   = 1'b0;
                                w_ret_nxt    = S_OP_WAIT;
                                w_go_refresh = 1'b1;
                            end
                        end else if (r_state == S_OP_WAIT) begin
                            w_op_nxt = w_op_sel;
                        end else begin
                            w_go_err = 1'b1;
                        end
                    end else if (i_cmd == CMD_EQ) begin
                        if (r_state == S_ENT_B) begin
                            case (r_op)
                                OP_ADD: begin
                                    if (w_sum > MAXVAL) begin
                                        w_go_err = 1'b1;
                                    end else begin
                                        w_value_nxt  = WIDTH'(w_sum);
                                        w_neg_nxt    = 1'b0;
                                        w_done_nxt   = 1'b1;
                                        w_ret_nxt    = S_ENT_A;
                                        w_go_refresh = 1'b1;
                                    end
                                end
                                OP_SUB: begin
                                    if (r_rega < r_value) begin
                                        w_value_nxt = r_value - r_rega;
                                        w_neg_nxt   = 1'b1;
                                    end else begin
                                        w_value_nxt = r_rega - r_value;
                                        w_neg_nxt   = 1'b0;
                                    end
                                    w_done_nxt   = 1'b1;
                                    w_ret_nxt    = S_ENT_A;
                                    w_go_refresh = 1'b1;
                                end
                                OP_MUL: begin
                                    w_state_nxt  = S_MUL;
                                    w_status_nxt = ST_BUSY;
                                    w_cnt_nxt    = '0;
                                    w_mcand_nxt  = PROD_W'(r_rega);
                                    w_mplier_nxt = r_value;
                                    w_prod_nxt   = '0;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        // Backspace; OP_WAIT has no operand being edited
                        if (r_state != S_OP_WAIT) begin
                            w_value_nxt  = r_value / WIDTH'(10);
                            w_done_nxt   = 1'b0;
                            w_ret_nxt    = r_state;
                            w_go_refresh = 1'b1;
                        end
                    end
                end
            end
            S_MUL: begin
                w_prod_nxt   = w_prod_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_MUL_LAST) begin
                    if (w_prod_step > MAXVAL) begin
                        w_go_err = 1'b1;
                    end else begin
                        w_value_nxt  = WIDTH'(w_prod_step);
                        w_neg_nxt    = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_ret_nxt    = S_ENT_A;
                        w_go_refresh = 1'b1;
                    end
                end
            end
            S_REFRESH: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt < CNT_CONV_END) begin
                    w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_bin[WIDTH-1]};
                    w_bin_nxt = {r_bin[WIDTH-2:0], 1'b0};
                end else if (r_cnt < CNT_DISP_END) begin
                    w_disp_we_nxt = 1'b1;
                    w_pos_nxt     = POS_W'(w_digit_idx);
                    w_data_nxt    = w_digit;
                end else begin
                    w_pos_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_status_nxt = ST_READY;
                    w_state_nxt  = r_ret;
                end
            end
            S_ERR: begin
                if (i_cmd_valid && (i_cmd == CMD_CLR)) w_clear = 1'b1;
            end
            default: w_go_err = 1'b1;
        endcase

        if (w_clear) begin
            w_value_nxt  = '0;
            w_rega_nxt   = '0;
            w_op_nxt     = OP_NONE;
            w_neg_nxt    = 1'b0;
            w_done_nxt   = 1'b0;
            w_ret_nxt    = S_ENT_A;
            w_go_refresh = 1'b1;
        end
        if (w_go_refresh) begin
            w_state_nxt  = S_REFRESH;
            w_status_nxt = ST_BUSY;
            w_cnt_nxt    = '0;
            w_bin_nxt    = w_value_nxt;
            w_bcd_nxt    = '0;
        end
        if (w_go_err) begin
            w_state_nxt  = S_ERR;
            w_status_nxt = ST_ERR;
        end
    end

    // Reset lands in REFRESH with value 0 so a zero display runs on release
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_REFRESH;
            r_ret     <= S_ENT_A;
            r_value   <= '0;
            r_rega    <= '0;
            r_op      <= OP_NONE;
            r_neg     <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_status  <= ST_BUSY;
            r_data    <= 4'd0;
            r_pos     <= '0;
            r_disp_we <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_value   <= w_value_nxt;
            r_rega    <= w_rega_nxt;
            r_op      <= w_op_nxt;
            r_neg     <= w_neg_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bin     <= w_bin_nxt;
            r_bcd     <= w_bcd_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_prod    <= w_prod_nxt;
            r_status  <= w_status_nxt;
            r_data    <= w_data_nxt;
            r_pos     <= w_pos_nxt;
            r_disp_we <= w_disp_we_nxt;
        end
    end

    assign o_status  = r_status;
    assign o_data    = r_data;
    assign o_pos     = r_pos;
    assign o_disp_we = r_disp_we;
    assign o_neg     = r_neg;
    assign o_state   = r_state;

endmodule
